axi_tlb_l1_seq: RTL and testbench

Multi-channel, sequentially searched L1 translation engine. It is the next generation of the L1 lookup used by the AXI TLB top levels. NumChan independent request channels share one lookup engine through round-robin arbitration. The entry table is scanned EntriesPerCycle entries per cycle, so depth scales without a full-width comparator array. It adds write-permission faults, a per-request bypass snapshot and a saturating miss counter. It sits between the AW/AR forks and the hit/miss demultiplexer of a TLB top level.

---
 rtl/axi_tlb_l1_seq.sv | 208 ++++++++++++++++++++
 tb/tb_axi_tlb_l1_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_tlb_l1_seq.sv
// Sequentially searched, multi-channel L1 translation engine.
// Round-robin arbitrated request channels share one engine that scans the
// entry table EntriesPerCycle entries per cycle.
module axi_tlb_l1_seq #(
   parameter int unsigned NumChan         = 2,
   parameter int unsigned InpAddrWidth    = 48,
   parameter int unsigned OupAddrWidth    = 48,
   parameter int unsigned PageWidth       = 12,
   parameter int unsigned NumEntries      = 16,
   parameter int unsigned EntriesPerCycle = 4,
   parameter int unsigned CntWidth        = 16
) (
   input  logic                                          clk_i,
   input  logic                                          rst_i,
   input  logic [NumChan-1:0]                            req_valid_i,
   output logic [NumChan-1:0]                            req_ready_o,
   input  logic [NumChan*InpAddrWidth-1:0]               req_addr_i,
   input  logic [NumChan-1:0]                            req_write_i,
   output logic [NumChan-1:0]                            res_valid_o,
   input  logic [NumChan-1:0]                            res_ready_i,
   output logic                                          res_hit_o,
   output logic [1:0]                                    res_fault_o,
   output logic [OupAddrWidth-1:0]                       res_addr_o,
   input  logic [NumEntries-1:0]                         entry_valid_i,
   input  logic [NumEntries-1:0]                         entry_ro_i,
   input  logic [NumEntries*(InpAddrWidth-PageWidth)-1:0] entry_first_i,
   input  logic [NumEntries*(InpAddrWidth-PageWidth)-1:0] entry_last_i,
   input  logic [NumEntries*(OupAddrWidth-PageWidth)-1:0] entry_base_i,
   input  logic                                          bypass_i,
   output logic                                          busy_o,
   output logic [CntWidth-1:0]                           miss_cnt_o
);

   localparam int unsigned InpPageWidth  = InpAddrWidth - PageWidth;
   localparam int unsigned OupPageWidth  = OupAddrWidth - PageWidth;
   localparam int unsigned NumGroups     = NumEntries / EntriesPerCycle;
   localparam int unsigned ChanIdxWidth  = (NumChan > 1) ? $clog2(NumChan) : 1;
   localparam int unsigned GroupIdxWidth = (NumGroups > 1) ? $clog2(NumGroups) : 1;
   localparam int unsigned EntIdxWidth   = (NumEntries > 1) ? $clog2(NumEntries) : 1;

   if (NumEntries % EntriesPerCycle != 0) begin : g_bad_groups
      $error("NumEntries must be a multiple of EntriesPerCycle");
   end
   if (PageWidth >= InpAddrWidth) begin : g_bad_inp_page
      $error("PageWidth must be smaller than InpAddrWidth");
   end
   if (PageWidth >= OupAddrWidth) begin : g_bad_oup_page
      $error("PageWidth must be smaller than OupAddrWidth");
   end

   typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, RESP = 2'd2} state_e;

   state_e                    state;
   logic [ChanIdxWidth-1:0]   rr_ptr;
   logic [ChanIdxWidth-1:0]   chan;
   logic [InpAddrWidth-1:0]   addr_q;
   logic                      write_q;
   logic [GroupIdxWidth-1:0]  group;

   logic [InpAddrWidth-1:0]   addr_arr  [NumChan];
   logic [InpPageWidth-1:0]   first_arr [NumEntries];
   logic [InpPageWidth-1:0]   last_arr  [NumEntries];
   logic [OupPageWidth-1:0]   base_arr  [NumEntries];

   logic                      grant_any;
   logic [ChanIdxWidth-1:0]   grant_idx;
   int unsigned               cand;

   logic [InpPageWidth-1:0]   page;
   logic [EntIdxWidth-1:0]    ent_idx;
   logic                      match;
   logic                      m_ro;
   logic [InpPageWidth-1:0]   m_first;
   logic [OupPageWidth-1:0]   m_base;

   // Unpack flat channel and entry buses into indexable arrays.
   for (genvar i = 0; i < NumChan; i++) begin : g_chan
      assign addr_arr[i] = req_addr_i[i*InpAddrWidth +: InpAddrWidth];
   end
   for (genvar i = 0; i < NumEntries; i++) begin : g_ent
      assign first_arr[i] = entry_first_i[i*InpPageWidth +: InpPageWidth];
      assign last_arr[i]  = entry_last_i[i*InpPageWidth +: InpPageWidth];
      assign base_arr[i]  = entry_base_i[i*OupPageWidth +: OupPageWidth];
   end

   // Round-robin pick: first valid channel at or after rr_ptr.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = 0;
      for (int unsigned i = 0; i < NumChan; i++) begin
         cand = 32'(rr_ptr) + i;
         if (cand >= NumChan) cand = cand - NumChan;
         if (!grant_any && req_valid_i[cand]) begin
            grant_any = 1'b1;
            grant_idx = ChanIdxWidth'(cand);
         end
      end
   end

   // Ready only for the granted channel while idle.
   always_comb begin
      req_ready_o = '0;
      if (state == IDLE && !rst_i && grant_any) req_ready_o[grant_idx] = 1'b1;
   end

   // Compare the current group; lowest index wins.
   always_comb begin
      page    = addr_q[InpAddrWidth-1:PageWidth];
      match   = 1'b0;
      m_ro    = 1'b0;
      m_first = '0;
      m_base  = '0;
      ent_idx = '0;
      for (int unsigned j = 0; j < EntriesPerCycle; j++) begin
         ent_idx = EntIdxWidth'(32'(group) * EntriesPerCycle + j);
         if (!match && entry_valid_i[ent_idx] &&
             first_arr[ent_idx] <= page && page <= last_arr[ent_idx]) begin
            match   = 1'b1;
            m_ro    = entry_ro_i[ent_idx];
            m_first = first_arr[ent_idx];
            m_base  = base_arr[ent_idx];
         end
      end
   end

   // Engine FSM with registered result, busy and miss counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         chan        <= '0;
         addr_q      <= '0;
         write_q     <= 1'b0;
         group       <= '0;
         res_valid_o <= '0;
         res_hit_o   <= 1'b0;
         res_fault_o <= 2'd0;
         res_addr_o  <= '0;
         busy_o      <= 1'b0;
         miss_cnt_o  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  chan    <= grant_idx;
                  rr_ptr  <= (32'(grant_idx) == NumChan - 1) ? '0 : grant_idx + 1'b1;
                  addr_q  <= addr_arr[grant_idx];
                  write_q <= req_write_i[grant_idx];
                  group   <= '0;
                  busy_o  <= 1'b1;
                  if (bypass_i) begin
                     state       <= RESP;
                     res_valid_o <= NumChan'(1) << grant_idx;
                     res_hit_o   <= 1'b1;
                     res_fault_o <= 2'd0;
                     res_addr_o  <= OupAddrWidth'(addr_arr[grant_idx]);
                  end else begin
                     state <= SEARCH;
                  end
               end
            end
            SEARCH: begin
               if (match) begin
                  state       <= RESP;
                  res_valid_o <= NumChan'(1) << chan;
                  if (write_q && m_ro) begin
                     res_hit_o   <= 1'b0;
                     res_fault_o <= 2'd2;
                     res_addr_o  <= '0;
                  end else begin
                     res_hit_o   <= 1'b1;
                     res_fault_o <= 2'd0;
                     res_addr_o  <= {m_base + OupPageWidth'(page - m_first),
                                     addr_q[PageWidth-1:0]};
                  end
               end else if (group == GroupIdxWidth'(NumGroups - 1)) begin
                  state       <= RESP;
                  res_valid_o <= NumChan'(1) << chan;
                  res_hit_o   <= 1'b0;
                  res_fault_o <= 2'd1;
                  res_addr_o  <= '0;
               end else begin
                  group <= group + 1'b1;
               end
            end
            RESP: begin
               if (res_ready_i[chan]) begin
                  state       <= IDLE;
                  res_valid_o <= '0;
                  busy_o      <= 1'b0;
                  if (!res_hit_o && miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Request payload must hold while valid waits for ready.
   for (genvar c = 0; c < NumChan; c++) begin : g_chk
      a_stable_payload : assert property (@(posedge clk_i) disable iff (rst_i)
         (req_valid_i[c] && !req_ready_o[c]) |=>
         (!req_valid_i[c] || ($stable(addr_arr[c]) && $stable(req_write_i[c]))))
         else $error("request payload changed while waiting on channel %0d", c);
   end

endmodule

// File: tb/tb_axi_tlb_l1_seq.sv
// Directed bench for axi_tlb_l1_seq: 4 entries, 2 per cycle, 32-bit addresses.
module tb_axi_tlb_l1_seq;

   localparam int unsigned NumChan  = 2;
   localparam int unsigned AW       = 32;
   localparam int unsigned PW       = 12;
   localparam int unsigned NE       = 4;
   localparam int unsigned EPC      = 2;
   localparam int unsigned CW       = 4;
   localparam int unsigned PgW      = AW - PW;

   logic                 clk;
   logic                 rst;
   logic [NumChan-1:0]   req_valid;
   logic [NumChan-1:0]   req_ready;
   logic [AW-1:0]        addr_a [NumChan];
   logic [NumChan*AW-1:0] req_addr;
   logic [NumChan-1:0]   req_write;
   logic [NumChan-1:0]   res_valid;
   logic [NumChan-1:0]   res_ready;
   logic                 res_hit;
   logic [1:0]           res_fault;
   logic [AW-1:0]        res_addr;
   logic [NE-1:0]        entry_valid;
   logic [NE-1:0]        entry_ro;
   logic [NE*PgW-1:0]    entry_first;
   logic [NE*PgW-1:0]    entry_last;
   logic [NE*PgW-1:0]    entry_base;
   logic                 bypass;
   logic                 busy;
   logic [CW-1:0]        miss_cnt;

   int n_vec = 0;
   int n_err = 0;

   assign req_addr = {addr_a[1], addr_a[0]};

   axi_tlb_l1_seq #(
      .NumChan(NumChan), .InpAddrWidth(AW), .OupAddrWidth(AW), .PageWidth(PW),
      .NumEntries(NE), .EntriesPerCycle(EPC), .CntWidth(CW)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_addr_i(req_addr), .req_write_i(req_write),
      .res_valid_o(res_valid), .res_ready_i(res_ready),
      .res_hit_o(res_hit), .res_fault_o(res_fault), .res_addr_o(res_addr),
      .entry_valid_i(entry_valid), .entry_ro_i(entry_ro),
      .entry_first_i(entry_first), .entry_last_i(entry_last),
      .entry_base_i(entry_base), .bypass_i(bypass),
      .busy_o(busy), .miss_cnt_o(miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one request, wait for its result; lat counts cycles from the accept edge.
   task automatic send(input logic ch, input logic [AW-1:0] a, input logic wr,
                       input logic byp, output int lat);
      int t;
      @(negedge clk);
      addr_a[ch]    = a;
      req_write[ch] = wr;
      req_valid[ch] = 1'b1;
      bypass        = byp;
      #1;
      t = 0;
      while (!req_ready[ch] && t < 20) begin
         @(negedge clk);
         #1;
         t++;
      end
      check("grant", 64'(req_ready[ch]), 64'(1));
      @(posedge clk);
      @(negedge clk);
      req_valid[ch] = 1'b0;
      bypass        = 1'b0;
      lat = 1;
      while (!res_valid[ch] && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // Complete the response handshake on one channel.
   task automatic accept(input logic ch);
      res_ready[ch] = 1'b1;
      @(negedge clk);
      res_ready[ch] = 1'b0;
   endtask

   initial begin
      int lat;
      int gr [3];
      int ng;
      int t;
      rst         = 1'b1;
      req_valid   = 2'b11;
      req_write   = '0;
      res_ready   = '0;
      bypass      = 1'b0;
      addr_a[0]   = '0;
      addr_a[1]   = '0;
      entry_valid = 4'b1010;
      entry_ro    = 4'b1000;
      entry_first = '0;
      entry_last  = '0;
      entry_base  = '0;
      entry_first[1*PgW +: PgW] = 20'h00010;
      entry_last [1*PgW +: PgW] = 20'h0001F;
      entry_base [1*PgW +: PgW] = 20'h00800;
      entry_first[3*PgW +: PgW] = 20'h00040;
      entry_last [3*PgW +: PgW] = 20'h00040;
      entry_base [3*PgW +: PgW] = 20'h00900;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_res_valid", 64'(res_valid), 64'(0));
      check("rst_req_ready", 64'(req_ready), 64'(0));
      check("rst_busy",      64'(busy),      64'(0));
      check("rst_miss_cnt",  64'(miss_cnt),  64'(0));
      check("rst_hit",       64'(res_hit),   64'(0));
      check("rst_fault",     64'(res_fault), 64'(0));
      check("rst_addr",      64'(res_addr),  64'(0));
      rst       = 1'b0;
      req_valid = '0;

      // Read hit in group 0
      send(1'b0, 32'h0001_2345, 1'b0, 1'b0, lat);
      check("hit_lat",   64'(lat),       64'(2));
      check("hit_valid", 64'(res_valid), 64'(2'b01));
      check("hit_busy",  64'(busy),      64'(1));
      check("hit_hit",   64'(res_hit),   64'(1));
      check("hit_fault", 64'(res_fault), 64'(0));
      check("hit_addr",  64'(res_addr),  64'(32'h0080_2345));
      accept(1'b0);
      check("hit_miss_cnt", 64'(miss_cnt), 64'(0));
      check("hit_busy_done", 64'(busy), 64'(0));

      // Write to read-only entry in group 1
      send(1'b1, 32'h0004_0008, 1'b1, 1'b0, lat);
      check("perm_lat",   64'(lat),       64'(3));
      check("perm_valid", 64'(res_valid), 64'(2'b10));
      check("perm_hit",   64'(res_hit),   64'(0));
      check("perm_fault", 64'(res_fault), 64'(2));
      check("perm_addr",  64'(res_addr),  64'(0));
      accept(1'b1);
      check("perm_miss_cnt", 64'(miss_cnt), 64'(1));

      // Same page as a read
      send(1'b1, 32'h0004_0008, 1'b0, 1'b0, lat);
      check("ro_rd_hit",   64'(res_hit),   64'(1));
      check("ro_rd_fault", 64'(res_fault), 64'(0));
      check("ro_rd_addr",  64'(res_addr),  64'(32'h0090_0008));
      accept(1'b1);
      check("ro_rd_miss_cnt", 64'(miss_cnt), 64'(1));

      // Miss
      send(1'b0, 32'h0009_9000, 1'b0, 1'b0, lat);
      check("miss_lat",   64'(lat),       64'(3));
      check("miss_hit",   64'(res_hit),   64'(0));
      check("miss_fault", 64'(res_fault), 64'(1));
      check("miss_addr",  64'(res_addr),  64'(0));
      accept(1'b0);
      check("miss_miss_cnt", 64'(miss_cnt), 64'(2));

      // Bypass, dropped the cycle after acceptance
      send(1'b0, 32'hABCD_E123, 1'b0, 1'b1, lat);
      check("byp_lat",   64'(lat),       64'(1));
      check("byp_hit",   64'(res_hit),   64'(1));
      check("byp_fault", 64'(res_fault), 64'(0));
      check("byp_addr",  64'(res_addr),  64'(32'hABCD_E123));
      accept(1'b0);
      check("byp_miss_cnt", 64'(miss_cnt), 64'(2));

      // 17 more misses: 19 total = 2^CW + 3, counter saturates
      for (int i = 0; i < 17; i++) begin
         send(1'b0, 32'h0009_9000, 1'b0, 1'b0, lat);
         accept(1'b0);
      end
      check("sat_miss_cnt", 64'(miss_cnt), 64'(4'hF));

      // Stall response 5 cycles; other channel waits, other res_ready ignored
      send(1'b0, 32'h0001_2345, 1'b0, 1'b0, lat);
      addr_a[1]    = 32'h0001_3000;
      req_write[1] = 1'b0;
      req_valid[1] = 1'b1;
      res_ready[1] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("hold_valid", 64'(res_valid), 64'(2'b01));
         check("hold_addr",  64'(res_addr),  64'(32'h0080_2345));
         check("hold_ready", 64'(req_ready), 64'(0));
         @(negedge clk);
      end
      res_ready[1] = 1'b0;
      accept(1'b0);
      #1;
      check("after_hold_grant", 64'(req_ready), 64'(2'b10));
      @(posedge clk);
      @(negedge clk);
      req_valid[1] = 1'b0;
      t = 0;
      while (!res_valid[1] && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("ch1_hit",  64'(res_hit),  64'(1));
      check("ch1_addr", 64'(res_addr), 64'(32'h0080_3000));
      accept(1'b1);

      // Reset, then continuous requests on both channels alternate
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst2_miss_cnt", 64'(miss_cnt), 64'(0));
      addr_a[0] = 32'h0001_2345;
      addr_a[1] = 32'h0001_2345;
      req_write = '0;
      res_ready = 2'b11;
      req_valid = 2'b11;
      ng = 0;
      t  = 0;
      while (ng < 3 && t < 40) begin
         #1;
         if (req_ready[0]) begin
            gr[ng] = 0;
            ng++;
         end else if (req_ready[1]) begin
            gr[ng] = 1;
            ng++;
         end
         t++;
         @(negedge clk);
      end
      req_valid = '0;
      check("rr_count", 64'(ng), 64'(3));
      check("rr_grant0", 64'(gr[0]), 64'(0));
      check("rr_grant1", 64'(gr[1]), 64'(1));
      check("rr_grant2", 64'(gr[2]), 64'(0));
      repeat (4) @(negedge clk);
      check("rr_busy_done", 64'(busy), 64'(0));
      res_ready = '0;

      // Reset during group-1 search drops the request
      addr_a[0]    = 32'h0009_9000;
      req_valid[0] = 1'b1;
      #1;
      check("rs_grant", 64'(req_ready), 64'(2'b01));
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      res_ready = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("rs_no_valid", 64'(res_valid), 64'(0));
         check("rs_busy",     64'(busy),      64'(0));
         @(negedge clk);
      end
      res_ready    = '0;
      addr_a[0]    = 32'h0001_2345;
      addr_a[1]    = 32'h0009_9000;
      req_valid    = 2'b11;
      #1;
      check("rs_grant_ch0", 64'(req_ready), 64'(2'b01));
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      t = 0;
      while (!res_valid[0] && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("rs_next_valid", 64'(res_valid), 64'(2'b01));
      check("rs_next_hit",   64'(res_hit),   64'(1));
      check("rs_next_addr",  64'(res_addr),  64'(32'h0080_2345));
      accept(1'b0);
      check("rs_next_miss_cnt", 64'(miss_cnt), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
